// File: rtl/csatm_pkg.sv
// Shared constants, parameter bounds and types for the truncated CSA multiplier pipeline.
package csatm_pkg;

  localparam int unsigned NMin      = 2;
  localparam int unsigned NMax      = 32;
  localparam int unsigned StagesMin = 1;
  localparam int unsigned StagesMax = 4;
  localparam int unsigned SkipBsMin = 2;
  localparam int unsigned SkipBsMax = 8;

  // Product width for an n-bit operand pair.
  function automatic int unsigned pw(input int unsigned n);
    return 2 * n;
  endfunction

  // Elaboration-time legality of a parameter set.
  function automatic bit params_ok(input int unsigned n, input int unsigned k,
                                   input int unsigned stages, input int unsigned skip_bs);
    return (n >= NMin) && (n <= NMax) && (k <= n) &&
           (stages >= StagesMin) && (stages <= StagesMax) &&
           (skip_bs >= SkipBsMin) && (skip_bs <= SkipBsMax);
  endfunction

  // Redundant (sum, carry) pair, sized for the widest supported operand.
  typedef struct packed {
    logic [2*NMax-1:0] sum;
    logic [2*NMax-1:0] carry;
  } csa_vec_t;

endpackage

// File: rtl/u_csatm_pipe_if.sv
// Operand-in / product-out stream bundle of the truncated multiplier.
interface u_csatm_pipe_if
  import csatm_pkg::*;
#(
  parameter int unsigned N = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_trunc;
  logic             out_valid;
  logic             out_ready;
  logic [pw(N)-1:0] out_prod;
  logic             out_trunc;

  modport master (
    output in_valid, in_a, in_b, in_trunc, out_ready,
    input  in_ready, out_valid, out_prod, out_trunc
  );

  modport slave (
    input  in_valid, in_a, in_b, in_trunc, out_ready,
    output in_ready, out_valid, out_prod, out_trunc
  );

endinterface

// File: rtl/u_cska_n.sv
// Combinational carry-skip adder: ripple inside each BS-bit block, block carry bypassed
// when every bit of the block propagates.
module u_cska_n #(
  parameter int unsigned W  = 16,
  parameter int unsigned BS = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  localparam int unsigned NBlk = (W + BS - 1) / BS;

  logic [W-1:0]  p;
  logic [W-1:0]  g;
  logic [W-1:0]  s_bits;
  logic [NBlk:0] bc;
  logic          rc;
  logic          bp;

  // Ripple within a block; the skip mux picks the block carry-in when the block propagates.
  always_comb begin
    p      = a ^ b;
    g      = a & b;
    s_bits = '0;
    bc     = '0;
    rc     = 1'b0;
    bp     = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      if (i % BS == 0) begin
        rc = bc[i / BS];
        bp = 1'b1;
      end
      s_bits[i] = p[i] ^ rc;
      rc        = g[i] | (p[i] & rc);
      bp        = bp & p[i];
      if ((i % BS == BS - 1) || (i == W - 1)) begin
        bc[i / BS + 1] = bp ? bc[i / BS] : rc;
      end
    end
    sum = {bc[NBlk], s_bits};
  end

endmodule

// File: rtl/u_csatm_pipe.sv
// Pipelined unsigned truncated carry-save array multiplier with a carry-skip final adder
// and a valid/ready stream interface. The whole pipeline advances together on adv.
module u_csatm_pipe
  import csatm_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned K       = 4,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned SKIP_BS = 4
) (
  input logic          clk,
  input logic          rst_n,
  u_csatm_pipe_if.slave s
);

  localparam int unsigned  P     = pw(N);
  localparam int unsigned  H     = N / 2;
  // Clearing operand bits below K drops every a[i]&b[j] term with i<K or j<K.
  localparam logic [N-1:0] KMask = {N{1'b1}} << K;

  if (!params_ok(N, K, STAGES, SKIP_BS)) begin : g_bad_params
    $fatal(1, "u_csatm_pipe: parameter out of range");
  end

  typedef struct packed {
    logic         vld;
    logic         trunc;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [P-1:0] sum;
    logic [P-1:0] carry;
  } stage_t;

  // Fold multiplier rows [lo, hi) into the redundant sum/carry pair with 3:2 compressors.
  function automatic stage_t csa_rows(input stage_t st, input int unsigned lo,
                                      input int unsigned hi);
    stage_t       r;
    logic [P-1:0] pp;
    logic [P-1:0] sm;
    logic [P-1:0] cy;
    r = st;
    for (int unsigned j = lo; j < hi; j++) begin
      pp      = {P{r.b[j]}} & (P'(r.a) << j);
      sm      = r.sum ^ r.carry ^ pp;
      cy      = ((r.sum & r.carry) | (r.sum & pp) | (r.carry & pp)) << 1;
      r.sum   = sm;
      r.carry = cy;
    end
    return r;
  endfunction

  logic         adv;
  stage_t       pp_c, pp_s, mid_c, mid_s, arr_c, arr_s;
  logic [P:0]   add_out;
  logic         out_valid_q;
  logic         out_trunc_q;
  logic [P-1:0] out_prod_q;
  logic         unused_cout;
  logic [2*N-1:0] unused_ops;

  assign adv        = ~out_valid_q | s.out_ready;
  assign s.in_ready = adv;

  // Partial-product generation: operand masking by mode, empty redundant pair.
  always_comb begin
    pp_c       = '0;
    pp_c.vld   = s.in_valid;
    pp_c.trunc = s.in_trunc;
    pp_c.a     = s.in_trunc ? (s.in_a & KMask) : s.in_a;
    pp_c.b     = s.in_trunc ? (s.in_b & KMask) : s.in_b;
  end

  if (STAGES >= 3) begin : g_cut_pp
    // Register after partial-product generation.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   pp_s <= '0;
      else if (adv) pp_s <= pp_c;
    end
  end else begin : g_pass_pp
    assign pp_s = pp_c;
  end

  assign mid_c = csa_rows(pp_s, 0, H);

  if (STAGES >= 4) begin : g_cut_mid
    // Register halfway down the array.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   mid_s <= '0;
      else if (adv) mid_s <= mid_c;
    end
  end else begin : g_pass_mid
    assign mid_s = mid_c;
  end

  assign arr_c = csa_rows(mid_s, H, N);

  if (STAGES >= 2) begin : g_cut_arr
    // Register after the full CSA array.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   arr_s <= '0;
      else if (adv) arr_s <= arr_c;
    end
  end else begin : g_pass_arr
    assign arr_s = arr_c;
  end

  u_cska_n #(
    .W  (P),
    .BS (SKIP_BS)
  ) u_final_add (
    .a   (arr_s.sum),
    .b   (arr_s.carry),
    .sum (add_out)
  );

  // The product always fits in P bits; operands are spent once the array is done.
  assign unused_cout = add_out[P];
  assign unused_ops  = {arr_s.a, arr_s.b};

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      out_trunc_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= arr_s.vld;
      out_prod_q  <= add_out[P-1:0];
      out_trunc_q <= arr_s.trunc;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_prod  = out_prod_q;
  assign s.out_trunc = out_trunc_q;

endmodule
